// File: rtl/stream_unaligner_pkg.sv
// Shared constants, FSM encoding and helpers for stream_unaligner.
// Buffer geometry is fixed; the data width is a top-level parameter.
package stream_unaligner_pkg;

   localparam int BUF_BYTES = 64;
   localparam int MAX_REQ   = 32;
   localparam int BUF_BITS  = BUF_BYTES * 8;
   localparam int CNT_W     = $clog2(BUF_BYTES + 1);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Mask covering the lowest n bytes of the buffer.
   function automatic logic [BUF_BITS-1:0] byte_mask(input int n);
      logic [BUF_BITS-1:0] ones;
      ones = '1;
      if (n >= BUF_BYTES) return ones;
      return ~(ones << (n * 8));
   endfunction

endpackage

// File: rtl/stream_unaligner_keep_to_len.sv
// Converts a byte-enable vector into a byte count and a contiguity flag.
// The count is the run of ones starting at byte 0.
module keep_to_len #(
   parameter int KW = 32,
   parameter int LW = 7
) (
   input  logic [KW-1:0] keep,
   output logic [LW-1:0] len,
   output logic          err
);

   logic run;

   // Count trailing ones; flag anything not of the form 2^n-1.
   always_comb begin
      len = '0;
      run = 1'b1;
      for (int i = 0; i < KW; i++) begin
         if (run && keep[i]) len = len + LW'(1);
         else                run = 1'b0;
      end
      err = (keep & (keep + KW'(1))) != '0;
   end

endmodule

// File: rtl/stream_unaligner.sv
// Re-chunks a packed byte stream into right-justified requested chunks.
// 64-byte buffer, byte 0 oldest; append and extract may share a cycle.
module stream_unaligner #(
   parameter int DATA_WIDTH = 256,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_WIDTH-1:0]   s_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_tkeep,
   input  logic                    s_tvalid,
   input  logic                    s_tlast,
   output logic                    s_tready,
   input  logic                    req_valid,
   input  logic [LEN_WIDTH-1:0]    req_len,
   output logic                    req_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [LEN_WIDTH-1:0]    out_len,
   output logic                    out_valid,
   output logic                    out_last,
   input  logic                    out_ready,
   output logic                    err
);

   import stream_unaligner_pkg::*;

   localparam int KW = DATA_WIDTH / 8;

   state_t              state_q, state_d;
   logic [BUF_BITS-1:0] buf_q, buf_d, beat_ext;
   logic [CNT_W-1:0]    cnt_q, cnt_d, take, rem, add, k_len;
   logic [DATA_WIDTH-1:0] chunk;
   logic last_seen, k_err, bad_req;
   logic acc_req, acc_beat, emit;

   keep_to_len #(
      .KW (KW),
      .LW (CNT_W)
   ) u_keep_to_len (
      .keep (s_tkeep),
      .len  (k_len),
      .err  (k_err)
   );

   // Handshakes, byte accounting and next buffer contents.
   always_comb begin
      bad_req   = 32'(req_len) > MAX_REQ;
      req_ready = (state_q != DONE)
               && (!out_valid || out_ready)
               && (bad_req || last_seen
                   || 32'(cnt_q) >= 32'(req_len));
      acc_req   = req_valid && req_ready;
      take      = '0;
      if (acc_req && !bad_req)
         take = (32'(req_len) > 32'(cnt_q)) ? cnt_q
                                             : CNT_W'(req_len);
      emit      = acc_req && !bad_req && (req_len != '0);
      rem       = cnt_q - take;
      s_tready  = (state_q == FILL) && (32'(rem) <= MAX_REQ);
      acc_beat  = s_tvalid && s_tready;
      add       = acc_beat ? k_len : '0;
      cnt_d     = rem + add;
      beat_ext  = '0;
      for (int i = 0; i < KW; i++)
         if (i < int'(k_len)) beat_ext[i*8 +: 8] = s_tdata[i*8 +: 8];
      chunk = '0;
      for (int i = 0; i < KW; i++)
         if (i < int'(take)) chunk[i*8 +: 8] = buf_q[i*8 +: 8];
      buf_d = (buf_q >> (8 * int'(take))) & byte_mask(int'(rem));
      if (acc_beat) buf_d = buf_d | (beat_ext << (8 * int'(rem)));
   end

   // FSM next state: fill until tlast, drain to empty, wait for last pop.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL:    if (acc_beat && s_tlast) state_d = DRAIN;
         DRAIN:   if (emit && rem == '0)   state_d = DONE;
         DONE:    if (out_valid && out_ready) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // State, buffer, sticky error and output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FILL;
         buf_q     <= '0;
         cnt_q     <= '0;
         last_seen <= 1'b0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_len   <= '0;
         out_data  <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         if (acc_beat && s_tlast)
            last_seen <= 1'b1;
         else if (state_q == DONE && out_valid && out_ready)
            last_seen <= 1'b0;
         if ((acc_req && bad_req) || (acc_beat && k_err))
            err <= 1'b1;
         if (emit) begin
            out_valid <= 1'b1;
            out_data  <= chunk;
            out_len   <= LEN_WIDTH'(take);
            out_last  <= (state_q == DRAIN) && (rem == '0);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_unaligner.sv
// Directed bench for stream_unaligner.
// One task per scenario with inline checks.
module tb_stream_unaligner;

   logic         clk = 1'b0;
   logic         reset;
   logic [255:0] s_tdata;
   logic [31:0]  s_tkeep;
   logic         s_tvalid, s_tlast, s_tready;
   logic         req_valid, req_ready;
   logic [7:0]   req_len;
   logic [255:0] out_data;
   logic [7:0]   out_len;
   logic         out_valid, out_last, out_ready, err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   stream_unaligner #(
      .DATA_WIDTH (256),
      .LEN_WIDTH  (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .s_tdata   (s_tdata),
      .s_tkeep   (s_tkeep),
      .s_tvalid  (s_tvalid),
      .s_tlast   (s_tlast),
      .s_tready  (s_tready),
      .req_valid (req_valid),
      .req_len   (req_len),
      .req_ready (req_ready),
      .out_data  (out_data),
      .out_len   (out_len),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .err       (err)
   );

   function automatic logic [255:0] seq_bytes(input int base, input int n);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[i*8 +: 8] = 8'(base + i);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      s_tvalid  = 1'b0;
      s_tlast   = 1'b0;
      s_tdata   = '0;
      s_tkeep   = '0;
      req_valid = 1'b0;
      req_len   = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic send_beat(input logic [255:0] d,
                            input logic [31:0] k,
                            input logic l);
      int n = 0;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      s_tvalid = 1'b1;
      #1;
      while (!s_tready && n < 16) begin
         tick();
         n++;
      end
      if (n == 16) begin
         n_tests++;
         n_fail++;
         $display("FAIL beat_timeout s_tready stuck at %b", s_tready);
      end
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic do_req(input int len);
      int n = 0;
      req_len   = 8'(len);
      req_valid = 1'b1;
      #1;
      while (!req_ready && n < 16) begin
         tick();
         n++;
      end
      if (n == 16) begin
         n_tests++;
         n_fail++;
         $display("FAIL req_timeout len %0d req_ready %b", len, req_ready);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      out_ready = 1'b1;
      req_len   = 8'd4;
      #1;
      n_tests++;
      if (s_tready !== 1'b1) begin
         n_fail++; $display("FAIL rst_s_tready got %b want 1", s_tready);
      end
      n_tests++;
      if (req_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_req_ready got %b want 0", req_ready);
      end
      n_tests++;
      if ({out_valid, out_last, err} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_flags got %b%b%b want 000",
                  out_valid, out_last, err);
      end
      n_tests++;
      if (out_len !== 8'd0 || out_data !== '0) begin
         n_fail++;
         $display("FAIL rst_out got len %0d data %h want 0",
                  out_len, out_data);
      end
   endtask

   task automatic test_chunks();
      logic [255:0] e;
      do_reset();
      out_ready = 1'b1;
      send_beat(seq_bytes(0, 32), '1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         do_req(4);
         e = seq_bytes(4 * k, 4);
         n_tests++;
         if (out_valid !== 1'b1 || out_len !== 8'd4 ||
             out_data !== e || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL chunk%0d got v%b len %0d last %b %h want %h",
                     k, out_valid, out_len, out_last, out_data, e);
         end
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL chunk_idle got %b want 0", out_valid);
      end
      do_req(0);
      n_tests++;
      if (out_valid !== 1'b0 || s_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_req got v%b rdy%b want v0 rdy1",
                  out_valid, s_tready);
      end
   endtask

   task automatic test_drain();
      logic [255:0] e;
      do_reset();
      out_ready = 1'b1;
      send_beat(seq_bytes(8'h40, 32), 32'hFFFF_FFFF, 1'b0);
      send_beat(seq_bytes(8'h80, 32), 32'h0000_FFFF, 1'b1);
      do_req(20);
      e = seq_bytes(8'h40, 20);
      n_tests++;
      if (out_valid !== 1'b1 || out_len !== 8'd20 ||
          out_last !== 1'b0 || out_data !== e) begin
         n_fail++;
         $display("FAIL drain1 got len %0d last %b %h want 20 0 %h",
                  out_len, out_last, out_data, e);
      end
      do_req(20);
      e = seq_bytes(8'h54, 12) | (seq_bytes(8'h80, 8) << 96);
      n_tests++;
      if (out_valid !== 1'b1 || out_len !== 8'd20 ||
          out_last !== 1'b0 || out_data !== e) begin
         n_fail++;
         $display("FAIL drain2 got len %0d last %b %h want 20 0 %h",
                  out_len, out_last, out_data, e);
      end
      do_req(20);
      e = seq_bytes(8'h88, 8);
      n_tests++;
      if (out_valid !== 1'b1 || out_len !== 8'd8 ||
          out_last !== 1'b1 || out_data !== e) begin
         n_fail++;
         $display("FAIL drain3 got len %0d last %b %h want 8 1 %h",
                  out_len, out_last, out_data, e);
      end
      n_tests++;
      if (req_ready !== 1'b0 || s_tready !== 1'b0) begin
         n_fail++;
         $display("FAIL done_ready got req %b s %b want 0 0",
                  req_ready, s_tready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || s_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL done_to_fill got v%b s_tready %b want 0 1",
                  out_valid, s_tready);
      end
   endtask

   task automatic test_backpressure();
      logic [255:0] e;
      do_reset();
      out_ready = 1'b1;
      send_beat(seq_bytes(0, 32), '1, 1'b0);
      out_ready = 1'b0;
      do_req(4);
      e = seq_bytes(0, 4);
      req_len = 8'd4;
      for (int c = 0; c < 5; c++) begin
         n_tests++;
         if (out_valid !== 1'b1 || out_data !== e ||
             out_len !== 8'd4 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold%0d got v%b len %0d rr%b %h want %h",
                     c, out_valid, out_len, req_ready, out_data, e);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release got v%b rr%b want 0 1",
                  out_valid, req_ready);
      end
   endtask

   task automatic test_errors();
      do_reset();
      out_ready = 1'b1;
      do_req(33);
      n_tests++;
      if (err !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_req got err %b v%b want 1 0", err, out_valid);
      end
      send_beat(seq_bytes(0, 32), '1, 1'b0);
      do_req(4);
      n_tests++;
      if (err !== 1'b1 || out_len !== 8'd4) begin
         n_fail++;
         $display("FAIL err_sticky got err %b len %0d want 1 4",
                  err, out_len);
      end
      do_reset();
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL err_clear got %b want 0", err);
      end
      send_beat(seq_bytes(8'h10, 32), 32'h0000_000B, 1'b0);
      n_tests++;
      if (err !== 1'b1 || dut.cnt_q !== 7'd2) begin
         n_fail++;
         $display("FAIL bad_keep got err %b cnt %0d want 1 2",
                  err, dut.cnt_q);
      end
      do_req(2);
      n_tests++;
      if (out_data !== seq_bytes(8'h10, 2) || out_len !== 8'd2) begin
         n_fail++;
         $display("FAIL bad_keep_data got len %0d %h want 2 1110",
                  out_len, out_data);
      end
   endtask

   task automatic test_concurrent();
      do_reset();
      out_ready = 1'b1;
      send_beat(seq_bytes(0, 32), '1, 1'b0);
      send_beat(seq_bytes(8'h20, 32), 32'h0000_00FF, 1'b0);
      n_tests++;
      if (dut.cnt_q !== 7'd40 || s_tready !== 1'b0) begin
         n_fail++;
         $display("FAIL cnt40 got cnt %0d s_tready %b want 40 0",
                  dut.cnt_q, s_tready);
      end
      s_tdata   = seq_bytes(8'h60, 32);
      s_tkeep   = '1;
      s_tvalid  = 1'b1;
      req_len   = 8'd16;
      req_valid = 1'b1;
      #1;
      n_tests++;
      if (s_tready !== 1'b1 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL both_ready got s %b r %b want 1 1",
                  s_tready, req_ready);
      end
      tick();
      s_tvalid  = 1'b0;
      req_valid = 1'b0;
      n_tests++;
      if (dut.cnt_q !== 7'd56 || out_len !== 8'd16 ||
          out_data !== seq_bytes(0, 16)) begin
         n_fail++;
         $display("FAIL cnt56 got cnt %0d len %0d %h want 56 16",
                  dut.cnt_q, out_len, out_data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      send_beat(seq_bytes(0, 32), '1, 1'b0);
      send_beat(seq_bytes(8'h20, 32), '1, 1'b0);
      do_req(14);
      n_tests++;
      if (dut.cnt_q !== 7'd50 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_rst got cnt %0d v%b want 50 1",
                  dut.cnt_q, out_valid);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests++;
      if (dut.cnt_q !== 7'd0 || out_valid !== 1'b0 ||
          s_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_rst got cnt %0d v%b s %b want 0 0 1",
                  dut.cnt_q, out_valid, s_tready);
      end
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL post_rst got v%b want 0", out_valid);
      end
   endtask

   initial begin
      reset     = 1'b1;
      out_ready = 1'b1;
      test_reset();
      test_chunks();
      test_drain();
      test_backpressure();
      test_errors();
      test_concurrent();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stream_unaligner.md
STREAM_UNALIGNER -- requirements
Module: stream_unaligner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, input/output data width in bits.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, request and result length width in bytes.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port s_tdata, input, DATA_WIDTH, packed stream word; byte 0 at LSB.
REQ-006 SHALL have port s_tkeep, input, DATA_WIDTH/8, contiguous-from-LSB byte enables.
REQ-007 SHALL have ports s_tvalid (input, 1), s_tlast (input, 1) and s_tready (output, 1), the input handshake.
REQ-008 SHALL have ports req_valid (input, 1), req_len (input, LEN_WIDTH) and req_ready (output, 1), the chunk request of 0..32 bytes.
REQ-009 SHALL have ports out_data (output, DATA_WIDTH, chunk right-justified, unused bytes zero) and out_len (output, LEN_WIDTH, bytes delivered).
REQ-010 SHALL have ports out_valid (output, 1), out_last (output, 1, final chunk of stream) and out_ready (input, 1).
REQ-011 SHALL have port err, output, 1, sticky flag set by an illegal request or illegal keep.

Function
REQ-012 SHALL hold a 64-byte buffer with byte count cnt (0..64); buffered byte 0 is always the oldest.
REQ-013 SHALL assert s_tready = (cnt - consumed_this_cycle <= 32) && state==FILL.
- consumed_this_cycle is the number of bytes accepted by a request in the same cycle.
REQ-014 SHALL append popcount(s_tkeep) bytes at offset cnt - consumed_this_cycle when s_tvalid && s_tready.
REQ-015 SHALL latch last_seen and move to state DRAIN when the accepted beat has s_tlast=1.
REQ-016 SHALL assert req_ready when (!out_valid || out_ready) && (cnt >= req_len || state==DRAIN); req_ready is deasserted in DONE.
REQ-017 SHALL, on an accepted request, register the first min(req_len, cnt) bytes into out_data/out_len with out_valid the next cycle, and shift the buffer down by that amount (1-cycle latency).
REQ-018 SHALL set out_last=1 when the request is accepted in DRAIN and leaves cnt=0, including a short chunk where out_len < req_len; the FSM then enters DONE.
REQ-019 SHALL go from DONE to FILL after out_valid && out_ready of the last chunk, clearing last_seen.
REQ-020 SHALL handle req_len=0 as accepted with no output beat and no state change.
REQ-021 SHALL, for req_len>32 or non-contiguous s_tkeep, set err, and:
- an illegal request is accepted and dropped;
- a beat with illegal keep appends the number of trailing-one bytes in its keep.
REQ-022 SHALL hold out_data/out_len/out_last stable while out_valid && !out_ready.
REQ-023 SHALL make an append and an extract in the same cycle consistent, with the new cnt = cnt - consumed + appended.
REQ-024 SHALL sustain one 32-byte beat in and one 32-byte chunk out per cycle in steady state.
- FSM states: FILL, DRAIN, DONE.

Reset
REQ-025 SHALL on reset set state=FILL, cnt=0, last_seen=0, out_valid=0, out_last=0, out_len=0, out_data=0, err=0.
- s_tready=1 and req_ready=0 (for nonzero req_len) in the cycle after reset.
REQ-026 SHALL make reset mid-stream discard all buffered bytes and any pending output beat, with no partial output afterwards.

Structure
REQ-027 SHALL place BUF_BYTES=64, MAX_REQ=32 and the FSM state encoding in shared package stream_unaligner_pkg.
REQ-028 SHALL use one sub-module, keep_to_len, converting s_tkeep to a byte count and a contiguity-error bit.

Verification
REQ-029 SHALL cover: one beat of 32 bytes 0x00..0x1F, then req_len=4 eight times -> eight chunks 03020100.., 07060504.., ..., all out_len=4.
REQ-030 SHALL cover: beat A (keep=0xFFFFFFFF), beat B (keep=0x0000FFFF, tlast), then req_len=20 three times -> out_len 20, 20, 8, with out_last=1 only on the third.
REQ-031 SHALL cover: out_ready=0 for 5 cycles with a pending chunk -> out_* held stable and req_ready=0 throughout.
REQ-032 SHALL cover: req_len=33 -> err=1 and no output beat; err stays 1 until reset.
REQ-033 SHALL cover: cnt=40 with a concurrent beat and req_len=16 -> beat accepted (24<=32), cnt=56 next cycle.
REQ-034 SHALL cover: reset asserted with cnt=50 and out_valid=1 -> next cycle cnt=0, out_valid=0, s_tready=1.
